// File: rtl/sqrt_check_seq.sv
// Sequential floor-sqrt checker: squares a candidate root with a shift-add
// multiplier, then checks root^2 <= x < (root+1)^2.
//
// state   | meaning
// S_IDLE  | waiting for start; results of the last check held
// S_MUL   | one shift-add squarer iteration per cycle, ROOT_W cycles
// S_CHECK | compare square against x and publish results, pulse done
module sqrt_check_seq #(
  parameter int ROOT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2*ROOT_W-1:0]   x,
  input  logic [ROOT_W-1:0]     root,
  output logic                  busy,
  output logic                  done,
  output logic [2*ROOT_W-1:0]   square,
  output logic [2*ROOT_W-1:0]   remainder,
  output logic                  ok,
  output logic                  too_big,
  output logic                  too_small
);

  localparam int XW    = 2 * ROOT_W;
  localparam int CNT_W = $clog2(ROOT_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CHECK} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic [XW-1:0]       acc_q, acc_d;
  logic [XW-1:0]       mcand_q, mcand_d;
  logic [ROOT_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XW-1:0]       square_q, square_d;
  logic [XW-1:0]       rem_q, rem_d;
  logic                ok_q, ok_d;
  logic                too_big_q, too_big_d;
  logic                too_small_q, too_small_d;

  // One extra bit so (root+1)^2 cannot wrap when root is all ones.
  logic [XW:0]         upper;
  logic                big_c;
  logic                small_c;

  assign upper   = {1'b0, acc_q} + {{ROOT_W{1'b0}}, root_q, 1'b0} + (XW+1)'(1);
  assign big_c   = acc_q > x_q;
  assign small_c = {1'b0, x_q} >= upper;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    root_d      = root_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    square_d    = square_q;
    rem_d       = rem_q;
    ok_d        = ok_q;
    too_big_d   = too_big_q;
    too_small_d = too_small_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d      = x;
          root_d   = root;
          acc_d    = '0;
          mcand_d  = {{ROOT_W{1'b0}}, root};
          mplier_d = root;
          cnt_d    = CNT_W'(ROOT_W - 1);
          busy_d   = 1'b1;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        square_d    = acc_q;
        rem_d       = x_q - acc_q;
        too_big_d   = big_c;
        too_small_d = small_c;
        ok_d        = !big_c && !small_c;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      root_q      <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      square_q    <= '0;
      rem_q       <= '0;
      ok_q        <= 1'b0;
      too_big_q   <= 1'b0;
      too_small_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      root_q      <= root_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      square_q    <= square_d;
      rem_q       <= rem_d;
      ok_q        <= ok_d;
      too_big_q   <= too_big_d;
      too_small_q <= too_small_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign square    = square_q;
  assign remainder = rem_q;
  assign ok        = ok_q;
  assign too_big   = too_big_q;
  assign too_small = too_small_q;

endmodule

// File: tb/tb_sqrt_check_seq.sv
// Scoreboard bench for sqrt_check_seq: driver pushes expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_sqrt_check_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [15:0] root = '0;
  logic        busy, done, ok, too_big, too_small;
  logic [31:0] square, remainder;

  sqrt_check_seq #(.ROOT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .root(root),
    .busy(busy), .done(done), .square(square), .remainder(remainder),
    .ok(ok), .too_big(too_big), .too_small(too_small)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sq;
    logic [31:0] rem;
    logic        ok;
    logic        tb;
    logic        ts;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency",   cyc - e.cyc, 32'd17);
          chk("busy_done", {31'd0, busy}, 32'd0);
          chk("square",    square, e.sq);
          chk("remainder", remainder, e.rem);
          chk("ok",        {31'd0, ok}, {31'd0, e.ok});
          chk("too_big",   {31'd0, too_big}, {31'd0, e.tb});
          chk("too_small", {31'd0, too_small}, {31'd0, e.ts});
        end
      end else if (q.size() > 0) begin
        chk("busy_held", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Drive start from the current negedge; accepted at the next posedge.
  task automatic drive(input logic [31:0] xv, input logic [15:0] rv,
                       input logic [31:0] esq, input logic [31:0] erem,
                       input logic eok, input logic etb, input logic ets);
    exp_t e;
    x = xv; root = rv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.sq = esq; e.rem = erem; e.ok = eok; e.tb = etb; e.ts = ets; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] xv, input logic [15:0] rv,
                       input logic [31:0] esq, input logic [31:0] erem,
                       input logic eok, input logic etb, input logic ets);
    @(negedge clk);
    drive(xv, rv, esq, erem, eok, etb, ets);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("timeout_pending", q.size(), 32'd0);
      q.delete();
    end
  endtask

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(v)) r = t;
    end
    return r[15:0];
  endfunction

  initial begin
    longint      xs;
    logic [15:0] r;
    logic [31:0] sq;

    #1;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_square", square, 32'd0);
    chk("rst_rem",    remainder, 32'd0);
    chk("rst_flags",  {29'd0, ok, too_big, too_small}, 32'd0);
    @(negedge clk); reset = 1'b0;

    issue(32'd0, 16'd0, 32'd0, 32'd0, 1, 0, 0);                          wait_idle();
    issue(32'hFFFF_FFFF, 16'hFFFF, 32'hFFFE_0001, 32'h0001_FFFE, 1, 0, 0); wait_idle();
    issue(32'hFFFF_FFFF, 16'hFFFE, 32'hFFFC_0004, 32'h0003_FFFB, 0, 0, 1); wait_idle();
    issue(32'd100, 16'd10, 32'd100, 32'd0, 1, 0, 0);                      wait_idle();
    issue(32'd99,  16'd10, 32'd100, 32'hFFFF_FFFF, 0, 1, 0);              wait_idle();
    issue(32'd121, 16'd10, 32'd100, 32'd21, 0, 0, 1);                     wait_idle();
    issue(32'd120, 16'd10, 32'd100, 32'd20, 1, 0, 0);                     wait_idle();
    issue(32'd0,   16'd1,  32'd1, 32'hFFFF_FFFF, 0, 1, 0);                wait_idle();
    issue(32'd3,   16'd1,  32'd1, 32'd2, 1, 0, 0);                        wait_idle();
    issue(32'd4,   16'd1,  32'd1, 32'd3, 0, 0, 1);                        wait_idle();

    // Start while busy is ignored; operand changes after acceptance ignored.
    issue(32'd100, 16'd10, 32'd100, 32'd0, 1, 0, 0);
    repeat (4) @(negedge clk);
    x = 32'd5; root = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: start during the done cycle.
    issue(32'd100, 16'd10, 32'd100, 32'd0, 1, 0, 0);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("b2b_done_seen", {31'd0, done}, 32'd1);
    drive(32'd50, 16'd7, 32'd49, 32'd1, 1, 0, 0);
    chk("b2b_done_drop", {31'd0, done}, 32'd0);
    chk("b2b_busy_rise", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset mid-operation discards it.
    issue(32'd121, 16'd10, 32'd100, 32'd21, 0, 0, 1);
    repeat (7) @(negedge clk);
    q.delete();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
    chk("mid_rst_done",   {31'd0, done}, 32'd0);
    chk("mid_rst_square", square, 32'd0);
    chk("mid_rst_rem",    remainder, 32'd0);
    chk("mid_rst_flags",  {29'd0, ok, too_big, too_small}, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (30) @(negedge clk);
    issue(32'd50, 16'd7, 32'd49, 32'd1, 1, 0, 0);
    wait_idle();

    // Sweep with floor-sqrt roots; every result must be ok.
    xs = 0;
    while (xs <= 64'hFFFF_FFFF) begin
      r  = isqrt(xs[31:0]);
      sq = 32'(r) * 32'(r);
      issue(xs[31:0], r, sq, xs[31:0] - sq, 1, 0, 0);
      wait_idle();
      xs += 3293 * 1000;
    end
    r  = isqrt(32'hFFFF_FFF0);
    sq = 32'(r) * 32'(r);
    issue(32'hFFFF_FFF0, r, sq, 32'hFFFF_FFF0 - sq, 1, 0, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
